// File: rtl/spi_slave_datapath.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_datapath
// Brief    : Oversampled SPI slave, all cpol/cpha modes, LSB-first, with a
//            one-entry transmit holding buffer and a pulsed receive word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_datapath #(
    parameter int SPI_MAX_WIDTH_LOG = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cpol,
    input  logic                                cpha,
    input  logic                                sck,
    input  logic                                cs_n,
    input  logic                                mosi,
    output logic                                miso,
    output logic                                miso_oe,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0]     tx_data,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0]     rx_data,
    output logic                                rx_valid,
    output logic                                tx_underrun,
    output logic                                busy
);

    localparam int                           c_width = 2**SPI_MAX_WIDTH_LOG;
    localparam logic [SPI_MAX_WIDTH_LOG-1:0] c_last  = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;

    logic [2:0]                     r_sck_sync;
    logic [2:0]                     r_cs_sync;
    logic [1:0]                     r_mosi_sync;
    logic [c_width-1:0]             r_buf;
    logic                           r_buf_full;
    logic [c_width-1:0]             r_tx_shift;
    logic [c_width-1:0]             r_rx_shift;
    logic [c_width-1:0]             r_rx_data;
    logic [SPI_MAX_WIDTH_LOG-1:0]   r_bit_cnt;
    logic                           r_first;
    logic                           r_rx_valid;
    logic                           r_tx_underrun;

    logic                           w_lead;
    logic                           w_trail;
    logic                           w_sample;
    logic                           w_shift;
    logic                           w_cs_fall;
    logic                           w_cs_rise;
    logic                           w_start;
    logic                           w_active;
    logic                           w_wrap;
    logic                           w_load;
    logic                           w_push;
    logic [c_width-1:0]             w_rx_next;

    // cs_n synchronizer resets low so a chip select already asserted at reset
    // release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], sck};
            r_cs_sync   <= {r_cs_sync[1:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    assign w_lead    = (r_sck_sync[1] != cpol) && (r_sck_sync[2] == cpol);
    assign w_trail   = (r_sck_sync[1] == cpol) && (r_sck_sync[2] != cpol);
    assign w_sample  = cpha ? w_trail : w_lead;
    assign w_shift   = cpha ? w_lead  : w_trail;
    assign w_cs_fall = !r_cs_sync[1] &&  r_cs_sync[2];
    assign w_cs_rise =  r_cs_sync[1] && !r_cs_sync[2];

    // A cs_n rise takes priority over a coincident sample edge.
    assign w_start   = (r_state == ST_IDLE) && w_cs_fall;
    assign w_active  = (r_state == ST_XFER) && !w_cs_rise;
    assign w_wrap    = w_active && w_sample && (r_bit_cnt == c_last);
    assign w_load    = w_start || w_wrap;
    assign w_push    = tx_valid && !r_buf_full;
    assign w_rx_next = {r_mosi_sync[1], r_rx_shift[c_width-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_next = ST_XFER;
            ST_XFER: if (w_cs_rise) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_bit_cnt     <= '0;
            r_first       <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= w_load && !r_buf_full;

            // No bypass: a word accepted on a load cycle waits for the next load.
            if (w_push) begin
                r_buf <= tx_data;
            end
            if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (w_push) begin
                r_buf_full <= 1'b1;
            end

            if (w_load) begin
                r_tx_shift <= r_buf_full ? r_buf : '0;
            end else if (w_active && w_shift && !(cpha && r_first)) begin
                r_tx_shift <= r_tx_shift >> 1;
            end

            if (w_start) begin
                r_bit_cnt <= '0;
                r_first   <= 1'b1;
            end else if ((r_state == ST_XFER) && w_cs_rise) begin
                r_bit_cnt <= '0;
            end else if (w_active && w_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == c_last) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_first    <= 1'b1;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                    r_first    <= 1'b0;
                end
            end
        end
    end

    assign miso        = (r_state == ST_XFER) ? r_tx_shift[0] : 1'b0;
    assign miso_oe     = (r_state == ST_XFER);
    assign busy        = (r_state == ST_XFER);
    assign tx_ready    = !r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire
